// File: rtl/thread_regfile_pkg.sv
// Shared core definitions: core FSM state codes, write-back mux codes,
// special-register indices and NZP flag bit positions.
package thread_regfile_pkg;

   localparam int unsigned NUM_REGS      = 16;
   localparam int unsigned REG_ADDR_BITS = 4;
   localparam int unsigned NZP_BITS      = 3;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'b000,
      CORE_FETCH   = 3'b001,
      CORE_DECODE  = 3'b010,
      CORE_REQUEST = 3'b011,
      CORE_WAIT    = 3'b100,
      CORE_EXECUTE = 3'b101,
      CORE_UPDATE  = 3'b110,
      CORE_DONE    = 3'b111
   } core_state_t;

   typedef enum logic [1:0] {
      MUX_ARITHMETIC = 2'b00,
      MUX_MEMORY     = 2'b01,
      MUX_CONSTANT   = 2'b10,
      MUX_RESERVED   = 2'b11
   } reg_input_mux_t;

   localparam int unsigned REG_BLOCK_IDX  = 13;
   localparam int unsigned REG_BLOCK_DIM  = 14;
   localparam int unsigned REG_THREAD_IDX = 15;

   localparam int unsigned NZP_NEG  = 0;
   localparam int unsigned NZP_ZERO = 1;
   localparam int unsigned NZP_POS  = 2;

endpackage

// File: rtl/thread_regfile.sv
// Per-thread register file: latches rs/rt operands in REQUEST, performs
// write-back and NZP capture in UPDATE. R13..R15 are read-only specials.
module thread_regfile
   import thread_regfile_pkg::*;
#(
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned THREAD_ID         = 0,
   parameter int unsigned DATA_BITS         = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [7:0]           block_id,
   input  logic [2:0]           core_state,
   input  logic [3:0]           decoded_rs_address,
   input  logic [3:0]           decoded_rt_address,
   input  logic [3:0]           decoded_rd_address,
   input  logic                 decoded_reg_write_enable,
   input  logic [1:0]           decoded_reg_input_mux,
   input  logic [7:0]           decoded_immediate,
   input  logic                 decoded_nzp_write_enable,
   input  logic [DATA_BITS-1:0] alu_out,
   input  logic [DATA_BITS-1:0] lsu_out,
   output logic [DATA_BITS-1:0] rs,
   output logic [DATA_BITS-1:0] rt,
   output logic [2:0]           nzp
);

   logic [DATA_BITS-1:0] regs [NUM_REGS];
   logic [DATA_BITS-1:0] wb_data_c;
   logic                 wb_en_c;
   core_state_t          state_c;

   assign state_c = core_state_t'(core_state);

   // Write-back source selection; the reserved mux code and special
   // registers suppress the write entirely.
   always_comb begin
      wb_data_c = '0;
      wb_en_c   = 1'b0;
      unique case (reg_input_mux_t'(decoded_reg_input_mux))
         MUX_ARITHMETIC: begin wb_data_c = alu_out;                      wb_en_c = 1'b1; end
         MUX_MEMORY:     begin wb_data_c = lsu_out;                      wb_en_c = 1'b1; end
         MUX_CONSTANT:   begin wb_data_c = DATA_BITS'(decoded_immediate); wb_en_c = 1'b1; end
         default:        begin wb_data_c = '0;                           wb_en_c = 1'b0; end
      endcase
      if (!decoded_reg_write_enable ||
          decoded_rd_address >= REG_ADDR_BITS'(REG_BLOCK_IDX))
         wb_en_c = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(REG_BLOCK_DIM); i++)
            regs[i] <= '0;
         regs[REG_BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
         regs[REG_THREAD_IDX] <= DATA_BITS'(THREAD_ID);
         rs  <= '0;
         rt  <= '0;
         nzp <= '0;
      end else if (enable) begin
         // One cycle of lag: a REQUEST in this cycle sees the previous block_id.
         regs[REG_BLOCK_IDX] <= DATA_BITS'(block_id);
         if (state_c == CORE_REQUEST) begin
            rs <= regs[decoded_rs_address];
            rt <= regs[decoded_rt_address];
         end
         if (state_c == CORE_UPDATE) begin
            if (wb_en_c)
               regs[decoded_rd_address] <= wb_data_c;
            if (decoded_nzp_write_enable)
               nzp <= alu_out[NZP_BITS-1:0];
         end
      end
   end

endmodule

// File: doc/thread_regfile.md
Name: thread_regfile

Overview:
- Per-thread register file: the source and sink end of the per-thread ALU interface.
- Supplies the rs/rt operands latched in REQUEST.
- Accepts the ALU result (or LSU data, or an immediate) for write-back in UPDATE.
- Captures CMP results into the thread's NZP flags.
- One instance per thread per core, alongside that thread's ALU and LSU.

Parameters:
THREADS_PER_BLOCK, 4, constant presented in R14 (block dimension)
THREAD_ID, 0, constant presented in R15 (thread index within block)
DATA_BITS, 8, register/operand width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  thread active; when low, all state holds
block_id  in  8  current block index, mirrored into R13
core_state  in  3  core FSM state (REQUEST=3'b011, UPDATE=3'b110; others idle for this block)
decoded_rs_address  in  4  source register 1 index
decoded_rt_address  in  4  source register 2 index
decoded_rd_address  in  4  destination register index
decoded_reg_write_enable  in  1  write rd during UPDATE
decoded_reg_input_mux  in  2  00 ALU, 01 LSU, 10 immediate, 11 reserved
decoded_immediate  in  8  constant for mux 10
decoded_nzp_write_enable  in  1  capture CMP result during UPDATE
alu_out  in  8  ALU result; for CMP, bits [2:0] = {gt, eq, lt}
lsu_out  in  8  load data
rs  out  8  operand 1 to ALU/LSU
rt  out  8  operand 2 to ALU/LSU
nzp  out  3  {positive, zero, negative} flags for branch evaluation

Behaviour:
Register map:
- 16 registers of DATA_BITS.
- R0–R12 are general purpose and read/write.
- R13 = block_id (read-only).
- R14 = THREADS_PER_BLOCK (read-only).
- R15 = THREAD_ID (read-only).

Reset (synchronous, wins over everything):
- R0–R12 = 0, R13 = 0.
- R14 = THREADS_PER_BLOCK, R15 = THREAD_ID.
- rs = 0, rt = 0, nzp = 3'b000.
- Reset mid-instruction discards any pending write or capture.

enable low:
- No register, rs, rt or nzp change, including R13.

enable high:
- Every cycle: R13 <= block_id. There is one cycle of lag, so block_id must be stable before REQUEST.

REQUEST (core_state == 3'b011):
- rs <= reg[decoded_rs_address]; rt <= reg[decoded_rt_address].
- Latency 1: valid from the first cycle of the following state (WAIT).
- Held until the next REQUEST or reset.
- Reading R13 returns the value registered before this edge.

UPDATE (core_state == 3'b110), register write:
- If decoded_reg_write_enable and decoded_rd_address < 13:
  - mux 00: reg[rd] <= alu_out
  - mux 01: reg[rd] <= lsu_out
  - mux 10: reg[rd] <= decoded_immediate
  - mux 11: no write
- Writes to R13–R15 are silently ignored; those registers keep their defined values.

UPDATE, NZP capture:
- If decoded_nzp_write_enable: nzp <= alu_out[2:0].
- This is independent of the register write; both may occur in the same cycle.

Other core states:
- No writes, no operand latch.
- rs/rt/nzp hold.

Hazards and width rules:
- Operand read and write-back occur in distinct states, so there is no read/write collision and no bypass is needed.
- Values are truncated to DATA_BITS; no sign extension.
- Address fields are exactly 4 bits, so there is no out-of-range case.

Implementation: single always block, 16-entry reg array; target about 150 RTL lines.

Decomposition:
Shared package (e.g. gpu_pkg) holds:
- Core state encodings IDLE..DONE (3'b000..3'b111).
- reg_input_mux codes: ARITHMETIC=2'b00, MEMORY=2'b01, CONSTANT=2'b10.
- Special-register indices: REG_BLOCK_IDX=13, REG_BLOCK_DIM=14, REG_THREAD_IDX=15.
- NZP bit positions.

The same package is shared by the ALU, decoder and PC unit. There is no natural sub-module; the block is a single module.

Test Plan:
1. Reset, THREADS_PER_BLOCK=4, THREAD_ID=2 -> R0..R12 read 0; R14 reads 4; R15 reads 2; nzp=000; rs=rt=0.
2. UPDATE with rd=3, mux=10, imm=0x2A, write_en=1 -> next REQUEST with rs_addr=3 gives rs=0x2A one cycle later; rt of R0 = 0.
3. UPDATE with rd=5, mux=00, alu_out=0x91 and mux=01, lsu_out=0x17 on R6 in successive instructions -> R5=0x91, R6=0x17; mux=11 to R7 leaves R7=0.
4. block_id=7 held, then REQUEST with rs_addr=13, rt_addr=15 -> rs=7, rt=THREAD_ID; UPDATE writing 0xFF to R13/R14/R15 -> values unchanged.
5. UPDATE with nzp_write_enable=1, alu_out=0x04 -> nzp=100. Then nzp_write_enable=0, alu_out=0x01 -> nzp stays 100. Then simultaneous rd=1 write of 0x01 with nzp capture -> R1=0x01, nzp=001.
6. enable=0 through REQUEST/UPDATE with write_en=1 -> rs, rt, registers and nzp unchanged. Reset asserted during UPDATE with a write pending -> target reads 0 after reset.
